// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared types and constants for the floating-point multiplier
//               family: operand class enum, flag bit positions, and constant
//               functions for the exponent bias and the canonical quiet NaN.
// Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

    typedef enum logic [1:0] {
        FP_ZERO = 2'd0,
        FP_NORM = 2'd1,
        FP_INF  = 2'd2,
        FP_NAN  = 2'd3
    } fpClass_t;

    // Flag vector layout: {invalid, inf_result, overflow, underflow, inexact}
    localparam int c_FLAG_W       = 5;
    localparam int c_FLAG_INVALID = 4;
    localparam int c_FLAG_INF     = 3;
    localparam int c_FLAG_OVF     = 2;
    localparam int c_FLAG_UNF     = 1;
    localparam int c_FLAG_INEXACT = 0;

    function automatic int fpBias(input int expW);
        return (1 << (expW - 1)) - 1;
    endfunction

    // Quiet NaN: positive sign, exponent all ones, fraction MSB set.
    function automatic logic [63:0] fpQnan(input int expW, input int manW);
        logic [63:0] v;
        v = ((64'd1 << expW) - 64'd1) << manW;
        v = v | (64'd1 << (manW - 1));
        return v;
    endfunction

    // Subnormals (exponent zero, any fraction) are reported as zero.
    function automatic fpClass_t fpClassify(input logic expZero, input logic expOnes,
                                            input logic fracZero);
        fpClass_t c;
        if (expZero)
            c = FP_ZERO;
        else if (expOnes)
            c = fracZero ? FP_INF : FP_NAN;
        else
            c = FP_NORM;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mult_round.sv
`default_nettype none
// ============================================================================
// Module      : fp_mult_round
// Description : Combinational normalize/round step of a floating-point
//               multiply. Takes the raw significand product and the biased
//               exponent sum, normalizes by at most one position, rounds and
//               renormalizes on rounding carry-out.
//               Build macro FP_MULT_RNE_EN selects round-to-nearest-even;
//               without it the result is truncated (round toward zero).
// Revision    : 1.0  initial release
// ============================================================================
module fp_mult_round
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic [2*MAN_W+1:0]      i_prod,
    input  logic signed [EXP_W+1:0] i_exp,
    output logic [MAN_W-1:0]        o_frac,
    output logic signed [EXP_W+1:0] o_exp,
    output logic                    o_inexact
);

    localparam logic signed [EXP_W+1:0] c_EXP_ONE = (EXP_W+2)'(1);

    logic [MAN_W:0]          w_sig;
    logic                    w_guard;
    logic                    w_round;
    logic                    w_sticky;
    logic signed [EXP_W+1:0] w_expNorm;
    logic [MAN_W+1:0]        w_sum;

    // Product of two [1,2) significands lies in [1,4): pick the window.
    always_comb begin
        if (i_prod[2*MAN_W+1]) begin
            w_sig     = i_prod[2*MAN_W+1:MAN_W+1];
            w_guard   = i_prod[MAN_W];
            w_round   = i_prod[MAN_W-1];
            w_sticky  = |i_prod[MAN_W-2:0];
            w_expNorm = i_exp + c_EXP_ONE;
        end else begin
            w_sig     = i_prod[2*MAN_W:MAN_W];
            w_guard   = i_prod[MAN_W-1];
            w_round   = i_prod[MAN_W-2];
            w_sticky  = |i_prod[MAN_W-3:0];
            w_expNorm = i_exp;
        end
    end

`ifdef FP_MULT_RNE_EN
    logic w_roundUp;
    assign w_roundUp = w_guard & (w_round | w_sticky | w_sig[0]);
    assign w_sum     = {1'b0, w_sig} + {{(MAN_W+1){1'b0}}, w_roundUp};
`else
    assign w_sum     = {1'b0, w_sig};
`endif

    // A carry out of the rounded significand means it became exactly 2.0.
    always_comb begin
        if (w_sum[MAN_W+1]) begin
            o_frac = w_sum[MAN_W:1];
            o_exp  = w_expNorm + c_EXP_ONE;
        end else begin
            o_frac = w_sum[MAN_W-1:0];
            o_exp  = w_expNorm;
        end
    end

    assign o_inexact = w_guard | w_round | w_sticky;

endmodule
`default_nettype wire

// File: rtl/fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_mult_pipe
// Description : Three-stage pipelined IEEE-754-style multiplier with
//               valid/ready flow control, flush-to-zero for subnormals and
//               per-result exception flags. Stage 1 unpacks and multiplies,
//               stage 2 normalizes/rounds, stage 3 packs and applies
//               exception priority. The whole pipe stalls while an output
//               is pending and not accepted.
//               Build macro FP_MULT_RNE_EN: round-to-nearest-even when
//               defined, truncation otherwise.
// Revision    : 1.0  initial release
// ============================================================================
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W  = 8,
    parameter  int MAN_W  = 7,
    localparam int DWIDTH = 1 + EXP_W + MAN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] result,
    output logic [4:0]        flags
);

    localparam logic signed [EXP_W+1:0] c_BIAS     = (EXP_W+2)'(fpBias(EXP_W));
    localparam logic signed [EXP_W+1:0] c_EXP_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+1:0] c_EXP_ZERO = '0;
    localparam logic [EXP_W-1:0]        c_EXP_ONES = '1;
    localparam logic [DWIDTH-1:0]       c_QNAN     = DWIDTH'(fpQnan(EXP_W, MAN_W));

    logic w_advance;

    // Stage 1 combinational unpack/multiply
    logic [EXP_W-1:0]        w_expA, w_expB;
    logic [MAN_W-1:0]        w_fracA, w_fracB;
    fpClass_t                w_classA, w_classB;
    logic [MAN_W:0]          w_manA, w_manB;
    logic [2*MAN_W+1:0]      w_prod;
    logic signed [EXP_W+1:0] w_expSum;

    // Stage 1 registers
    logic                    r_s1Valid;
    logic                    r_s1Sign;
    fpClass_t                r_s1ClassA, r_s1ClassB;
    logic [2*MAN_W+1:0]      r_s1Prod;
    logic signed [EXP_W+1:0] r_s1Exp;

    // Stage 2 combinational and registers
    logic [MAN_W-1:0]        w_rndFrac;
    logic signed [EXP_W+1:0] w_rndExp;
    logic                    w_rndInexact;
    logic                    r_s2Valid;
    logic                    r_s2Sign;
    fpClass_t                r_s2ClassA, r_s2ClassB;
    logic [MAN_W-1:0]        r_s2Frac;
    logic signed [EXP_W+1:0] r_s2Exp;
    logic                    r_s2Inexact;

    // Stage 3 combinational pack
    logic [DWIDTH-1:0]       w_packRes;
    logic [c_FLAG_W-1:0]     w_packFlags;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    assign w_expA   = a[DWIDTH-2:MAN_W];
    assign w_expB   = b[DWIDTH-2:MAN_W];
    assign w_fracA  = a[MAN_W-1:0];
    assign w_fracB  = b[MAN_W-1:0];
    assign w_classA = fpClassify(w_expA == '0, w_expA == c_EXP_ONES, w_fracA == '0);
    assign w_classB = fpClassify(w_expB == '0, w_expB == c_EXP_ONES, w_fracB == '0);
    assign w_manA   = (w_classA == FP_NORM) ? {1'b1, w_fracA} : '0;
    assign w_manB   = (w_classB == FP_NORM) ? {1'b1, w_fracB} : '0;
    assign w_prod   = {{(MAN_W+1){1'b0}}, w_manA} * {{(MAN_W+1){1'b0}}, w_manB};
    assign w_expSum = $signed({2'b00, w_expA}) + $signed({2'b00, w_expB}) - c_BIAS;

    // Stage 1 register: capture the unpacked operands on an input transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid  <= 1'b0;
            r_s1Sign   <= 1'b0;
            r_s1ClassA <= FP_ZERO;
            r_s1ClassB <= FP_ZERO;
            r_s1Prod   <= '0;
            r_s1Exp    <= '0;
        end else if (w_advance) begin
            r_s1Valid <= in_valid;
            if (in_valid) begin
                r_s1Sign   <= a[DWIDTH-1] ^ b[DWIDTH-1];
                r_s1ClassA <= w_classA;
                r_s1ClassB <= w_classB;
                r_s1Prod   <= w_prod;
                r_s1Exp    <= w_expSum;
            end
        end
    end

    fp_mult_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .i_prod    (r_s1Prod),
        .i_exp     (r_s1Exp),
        .o_frac    (w_rndFrac),
        .o_exp     (w_rndExp),
        .o_inexact (w_rndInexact)
    );

    // Stage 2 register: hold the rounded significand and final exponent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2Valid   <= 1'b0;
            r_s2Sign    <= 1'b0;
            r_s2ClassA  <= FP_ZERO;
            r_s2ClassB  <= FP_ZERO;
            r_s2Frac    <= '0;
            r_s2Exp     <= '0;
            r_s2Inexact <= 1'b0;
        end else if (w_advance) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2Sign    <= r_s1Sign;
                r_s2ClassA  <= r_s1ClassA;
                r_s2ClassB  <= r_s1ClassB;
                r_s2Frac    <= w_rndFrac;
                r_s2Exp     <= w_rndExp;
                r_s2Inexact <= w_rndInexact;
            end
        end
    end

    // Exception priority: NaN/invalid, inf, zero, overflow, underflow, normal
    always_comb begin
        w_packRes   = {r_s2Sign, r_s2Exp[EXP_W-1:0], r_s2Frac};
        w_packFlags = '0;
        w_packFlags[c_FLAG_INEXACT] = r_s2Inexact;
        if (r_s2ClassA == FP_NAN || r_s2ClassB == FP_NAN ||
            (r_s2ClassA == FP_INF && r_s2ClassB == FP_ZERO) ||
            (r_s2ClassA == FP_ZERO && r_s2ClassB == FP_INF)) begin
            w_packRes   = c_QNAN;
            w_packFlags = '0;
            w_packFlags[c_FLAG_INVALID] = 1'b1;
        end else if (r_s2ClassA == FP_INF || r_s2ClassB == FP_INF) begin
            w_packRes   = {r_s2Sign, c_EXP_ONES, {MAN_W{1'b0}}};
            w_packFlags = '0;
            w_packFlags[c_FLAG_INF] = 1'b1;
        end else if (r_s2ClassA == FP_ZERO || r_s2ClassB == FP_ZERO) begin
            w_packRes   = {r_s2Sign, {(EXP_W+MAN_W){1'b0}}};
            w_packFlags = '0;
        end else if (r_s2Exp >= c_EXP_MAX) begin
            w_packRes   = {r_s2Sign, c_EXP_ONES, {MAN_W{1'b0}}};
            w_packFlags = '0;
            w_packFlags[c_FLAG_OVF]     = 1'b1;
            w_packFlags[c_FLAG_INF]     = 1'b1;
            w_packFlags[c_FLAG_INEXACT] = 1'b1;
        end else if (r_s2Exp <= c_EXP_ZERO) begin
            w_packRes   = {r_s2Sign, {(EXP_W+MAN_W){1'b0}}};
            w_packFlags = '0;
            w_packFlags[c_FLAG_UNF]     = 1'b1;
            w_packFlags[c_FLAG_INEXACT] = 1'b1;
        end
    end

    // Stage 3 register: the outputs themselves, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (w_advance) begin
            out_valid <= r_s2Valid;
            if (r_s2Valid) begin
                result <= w_packRes;
                flags  <= w_packFlags;
            end
        end
    end

endmodule
`default_nettype wire
